// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default clocking and
// the bit-period helper used to size CLKS_PER_BIT.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  localparam int CLK_HZ       = 32_256_000;
  localparam int BAUD_DEFAULT = 115200;

  // Rounded to the nearest whole clock so odd ratios stay within half a cycle.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is
// chosen by the user so idle-high serial lines do not fake a start bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= RESET_VAL;
      q_o  <= RESET_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// Parametrised UART receiver with mid-bit sampling, false-start rejection,
// framing/overrun reporting and a valid/ready output. Optional parity: UART_RX_PARITY_EN.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD_DEFAULT),
  parameter int STOP_BITS    = 1
`ifdef UART_RX_PARITY_EN
  ,
  parameter logic PARITY_ODD = 1'b0
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  busy_o,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_err_o,
`endif
  output logic [2:0]            state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;
  localparam logic [2:0] S_BREAK  = BREAK;

  logic                  rx_s;
  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bad;
  logic                  bit_end;
  logic                  stop_sample;
  logic                  stop_fail;
  logic                  stop_done;
  logic                  frame_ok;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  always_comb begin
    bit_end     = (cnt == CNT_LAST);
    stop_sample = (state == S_STOP) && bit_end;
    stop_fail   = stop_sample && !rx_s;
    stop_done   = stop_sample && rx_s && (idx == STOP_LAST);
    frame_ok    = stop_done && !par_bad;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      cnt <= bit_end ? '0 : cnt + CW'(1);
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          // Re-check the line at mid start bit; a high line here was a glitch.
          if (cnt == CNT_MID) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
            if (idx == DATA_LAST) begin
              idx <= '0;
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_PARITY: begin
          if (bit_end) state <= S_STOP;
        end
        S_STOP: begin
          if (bit_end) begin
            if (!rx_s) begin
              idx   <= '0;
              state <= S_BREAK;
            end else if (idx == STOP_LAST) begin
              idx   <= '0;
              state <= S_IDLE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_bad <= 1'b0;
    end else if (state == S_IDLE) begin
      par_bad <= 1'b0;
    end else if ((state == S_PARITY) && bit_end) begin
      par_bad <= ((^shreg) ^ rx_s) != PARITY_ODD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) parity_err_o <= 1'b0;
    else         parity_err_o <= par_bad && (stop_done || stop_fail);
  end
`else
  assign par_bad = 1'b0;
`endif

  // Stream handshake: data_o is held stable while valid_o is high and is
  // consumed on any clock edge where valid_o && ready_i; a new frame may load
  // on that same edge, otherwise valid_o drops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= stop_fail;
      overrun_o   <= frame_ok && valid_o && !ready_i;
      if (frame_ok && (!valid_o || ready_i)) begin
        data_o  <= shreg;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  assign busy_o  = (state != S_IDLE);
  assign state_o = state;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream at default parameters; parity cases are
// included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_stream;

  localparam int CPB = 280;
  localparam int DW  = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx    = 1'b1;
  logic          ready = 1'b1;
  logic [DW-1:0] data;
  logic          valid;
  logic          ferr;
  logic          ovr;
  logic          busy;
  logic [2:0]    state;
`ifdef UART_RX_PARITY_EN
  logic          perr;
`endif

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_ovr   = 0;
  int n_perr  = 0;
  logic valid_q = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];

  always #5 clk = ~clk;

  uart_rx_stream dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_i        (rx),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .frame_err_o (ferr),
    .overrun_o   (ovr),
    .busy_o      (busy),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(perr),
`endif
    .state_o     (state)
  );

  // Monitor on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    valid_q <= valid;
    if (valid && !valid_q) n_valid <= n_valid + 1;
    if (ferr) n_ferr <= n_ferr + 1;
    if (ovr)  n_ovr  <= n_ovr + 1;
`ifdef UART_RX_PARITY_EN
    if (perr) n_perr <= n_perr + 1;
`endif
    if (valid && ready) got_q.push_back(data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag);
    logic [31:0] e;
    logic [31:0] g;
    e = 32'hEEEE;
    g = 32'hDEAD;
    if (exp_q.size() > 0) e = 32'(exp_q.pop_front());
    if (got_q.size() > 0) g = 32'(got_q.pop_front());
    check(tag, g, e);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready = v;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_v,
                            input logic par_en, input logic par_v);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (par_en) begin
      rx = par_v;
      repeat (CPB) @(negedge clk);
    end
    rx = stop_v;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    int base_v;
    int base_f;
    int base_o;
    int base_p;
    int k;

    // Reset values while reset is held
    repeat (4) @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: good frame 0xA5 with ready high
    base_v = n_valid; base_f = n_ferr; base_o = n_ovr;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check("a5_valid_pulses", 32'(n_valid - base_v), 32'd1);
    check_byte("a5_data");
    check("a5_ferr", 32'(n_ferr - base_f), 32'd0);
    check("a5_ovr", 32'(n_ovr - base_o), 32'd0);
    check("a5_busy_idle", 32'(busy), 32'd0);

    // 2: 100-clock glitch is rejected, then 0x3C is received
    base_v = n_valid;
    @(negedge clk);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_high", 32'(busy), 32'd1);
    k = 0;
    while (busy && k < 141) begin
      @(negedge clk);
      k++;
    end
    check("glitch_busy_low", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(n_valid - base_v), 32'd0);
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check_byte("3c_data");

    // 3: stop bit low for a full bit period gives one framing error
    base_v = n_valid; base_f = n_ferr;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check("ferr_pulses", 32'(n_ferr - base_f), 32'd1);
    check("ferr_no_valid", 32'(n_valid - base_v), 32'd0);
    check("ferr_busy_idle", 32'(busy), 32'd0);

    // 4: overrun with ready low, first byte held
    base_o = n_ovr; base_f = n_ferr;
    set_ready(1'b0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    check("ovr_valid_held", 32'(valid), 32'd1);
    check("ovr_data_held", 32'(data), 32'h11);
    check("ovr_pulses", 32'(n_ovr - base_o), 32'd1);
    check("ovr_no_ferr", 32'(n_ferr - base_f), 32'd0);
    set_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_cleared", 32'(valid), 32'd0);
    check_byte("ovr_data_taken");

    // 5: reset during data bit 4 of 0xFF
    base_v = n_valid; base_f = n_ferr; base_o = n_ovr;
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy_in_reset", 32'(busy), 32'd0);
    check("midrst_valid_in_reset", 32'(valid), 32'd0);
    rst_n = 1'b1;
    repeat (3000) @(negedge clk);
    check("midrst_no_valid", 32'(n_valid - base_v), 32'd0);
    check("midrst_no_ferr", 32'(n_ferr - base_f), 32'd0);
    check("midrst_no_ovr", 32'(n_ovr - base_o), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    check_byte("81_data");

`ifdef UART_RX_PARITY_EN
    // 6: even parity, correct then wrong parity bit on 0x07
    base_v = n_valid; base_p = n_perr;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check("par_ok_valid", 32'(n_valid - base_v), 32'd1);
    check_byte("par_ok_data");
    check("par_ok_no_perr", 32'(n_perr - base_p), 32'd0);
    base_v = n_valid; base_p = n_perr;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check("par_bad_perr", 32'(n_perr - base_p), 32'd1);
    check("par_bad_no_valid", 32'(n_valid - base_v), 32'd0);
`else
    base_p = n_perr;
    check("no_parity_perr", 32'(base_p), 32'd0);
`endif

    check("no_extra_bytes", 32'(got_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
